// File: rtl/key_input_pio.sv
// rtl/key_input_pio.sv - debounced push-button input port with Avalon-MM register access
module key_input_pio #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic             clk_50,
    input  logic             global_reset_n,
    input  logic [WIDTH-1:0] key_n,
    input  logic [1:0]       avs_address,
    input  logic             avs_read,
    input  logic             avs_write,
    input  logic [31:0]      avs_writedata,
    output logic [31:0]      avs_readdata,
    output logic             irq
);
    localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] state_q, state_d;
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] edge_q, edge_d;
    logic [15:0]      count_q, count_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [WIDTH-1:0] press;
    logic [4:0]       press_cnt;
    logic             wr_mask, wr_edge, wr_count;
    logic             unused_wdata;

    assign unused_wdata = ^avs_writedata;

    assign wr_mask  = avs_write && (avs_address == 2'd1);
    assign wr_edge  = avs_write && (avs_address == 2'd2);
    assign wr_count = avs_write && (avs_address == 2'd3);

    // A key only changes accepted state after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_comb begin
        state_d = state_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != state_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    state_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    assign press = state_d & ~state_q;

    always_comb begin
        press_cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            press_cnt = press_cnt + 5'(press[i]);
        end
    end

    // Same-cycle press beats the write-one-to-clear; a count clear still keeps this cycle's presses.
    always_comb begin
        mask_d  = wr_mask ? avs_writedata[WIDTH-1:0] : mask_q;
        edge_d  = (edge_q & ~(wr_edge ? avs_writedata[WIDTH-1:0] : {WIDTH{1'b0}})) | press;
        count_d = (wr_count ? 16'd0 : count_q) + 16'(press_cnt);
    end

    always_comb begin
        rdata_d = rdata_q;
        if (avs_read) begin
            case (avs_address)
                2'd0:    rdata_d = 32'(state_q);
                2'd1:    rdata_d = 32'(mask_q);
                2'd2:    rdata_d = 32'(edge_q);
                default: rdata_d = {16'd0, count_q};
            endcase
        end
    end

    always_ff @(posedge clk_50 or negedge global_reset_n) begin
        if (!global_reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            state_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
            mask_q  <= '0;
            edge_q  <= '0;
            count_q <= '0;
            rdata_q <= '0;
        end else begin
            sync1_q <= ~key_n;
            sync2_q <= sync1_q;
            state_q <= state_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            mask_q  <= mask_d;
            edge_q  <= edge_d;
            count_q <= count_d;
            rdata_q <= rdata_d;
        end
    end

    assign avs_readdata = rdata_q;
    assign irq          = |(edge_q & mask_q);

endmodule

// File: tb/tb_key_input_pio.sv
// tb/tb_key_input_pio.sv - self-checking bench for key_input_pio against a window-based model
module tb_key_input_pio;
    localparam int W = 4;
    localparam int D = 8;

    logic          clk_50 = 1'b0;
    logic          global_reset_n = 1'b0;
    logic [W-1:0]  key_n = 4'hF;
    logic [1:0]    avs_address = 2'd0;
    logic          avs_read = 1'b0;
    logic          avs_write = 1'b0;
    logic [31:0]   avs_writedata = 32'd0;
    logic [31:0]   avs_readdata;
    logic          irq;

    key_input_pio #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
        .clk_50        (clk_50),
        .global_reset_n(global_reset_n),
        .key_n         (key_n),
        .avs_address   (avs_address),
        .avs_read      (avs_read),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_readdata  (avs_readdata),
        .irq           (irq)
    );

    always #10 clk_50 = ~clk_50;

    int checks = 0;
    int errors = 0;

    // Model: a key's accepted state flips once the last D synchronised samples all disagree with it
    // and no flip happened inside that window; synchronised sample at edge e is the key seen at edge e-2.
    logic [W-1:0]  m_state, m_mask, m_edge;
    logic [15:0]   m_count;
    logic [31:0]   m_rd;
    logic [W-1:0]  hist [64];
    int            last_flip [W];
    int            valid_from;
    int            cyc = 0;
    logic          preset_ffff = 1'b0;

    always @(posedge clk_50) begin
        logic [W-1:0] nst, press;
        logic         all_diff, s;
        int           idx, pc;
        if (!global_reset_n) begin
            m_state = '0; m_mask = '0; m_edge = '0; m_count = '0; m_rd = '0;
            valid_from = cyc + 1;
            for (int k = 0; k < W; k++) last_flip[k] = cyc;
        end else begin
            if (preset_ffff) m_count = 16'hFFFF;
            nst = m_state;
            for (int k = 0; k < W; k++) begin
                all_diff = (cyc - last_flip[k]) >= D;
                for (int j = 0; j < D; j++) begin
                    idx = cyc - 2 - j;
                    s = (idx >= valid_from) ? hist[idx % 64][k] : 1'b0;
                    if (s == m_state[k]) all_diff = 1'b0;
                end
                if (all_diff) begin
                    nst[k] = ~m_state[k];
                    last_flip[k] = cyc;
                end
            end
            press = nst & ~m_state;
            pc = 0;
            for (int k = 0; k < W; k++) pc += int'(press[k]);
            if (avs_read) begin
                case (avs_address)
                    2'd0: m_rd = {28'd0, m_state};
                    2'd1: m_rd = {28'd0, m_mask};
                    2'd2: m_rd = {28'd0, m_edge};
                    default: m_rd = {16'd0, m_count};
                endcase
            end
            if (avs_write && avs_address == 2'd1) m_mask = avs_writedata[W-1:0];
            if (avs_write && avs_address == 2'd2) m_edge = m_edge & ~avs_writedata[W-1:0];
            m_edge = m_edge | press;
            if (avs_write && avs_address == 2'd3) m_count = 16'd0;
            m_count = m_count + 16'(pc);
            m_state = nst;
            hist[cyc % 64] = ~key_n;
        end
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk_50);
        avs_read = 1'b1; avs_address = a;
        @(negedge clk_50);
        avs_read = 1'b0;
        d = avs_readdata;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk_50);
        avs_write = 1'b1; avs_address = a; avs_writedata = d;
        @(negedge clk_50);
        avs_write = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_50);
    endtask

    logic [31:0] v;

    initial begin
        fork
            forever begin
                @(posedge clk_50);
                #1;
                check("model_readdata", avs_readdata, m_rd);
                check("model_irq", {31'd0, irq}, {31'd0, |(m_edge & m_mask)});
            end
        join_none

        // Reset with keys idle
        idle(3);
        global_reset_n = 1'b1;
        check("rst_irq", {31'd0, irq}, 32'd0);
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), v);
            check("rst_read", v, 32'd0);
        end

        // Clean press on key 0, DATA pinned to exactly D+1 edges after the change
        @(negedge clk_50);
        key_n = 4'hE; avs_read = 1'b1; avs_address = 2'd0;
        repeat (D + 2) @(posedge clk_50);
        #1 check("press0_before", avs_readdata, 32'h0);
        @(posedge clk_50);
        #1 check("press0_after", avs_readdata, 32'h1);
        @(negedge clk_50);
        avs_read = 1'b0;
        idle(10);
        rd(2'd2, v); check("press0_edge", v, 32'h1);
        rd(2'd3, v); check("press0_count", v, 32'h1);
        check("press0_irq_masked", {31'd0, irq}, 32'd0);
        wr(2'd1, 32'h1);
        check("press0_irq_on", {31'd0, irq}, 32'd1);

        // Bounce on key 1
        @(negedge clk_50); key_n[1] = 1'b0;
        idle(4);
        @(negedge clk_50); key_n[1] = 1'b1;
        idle(1);
        @(negedge clk_50); key_n[1] = 1'b0;
        rd(2'd0, v); check("bounce_data_hold", v, 32'h1);
        idle(15);
        rd(2'd0, v); check("bounce_data", v, 32'h3);
        rd(2'd3, v); check("bounce_count", v, 32'h2);

        // Two keys in one cycle with the count about to wrap
        wr(2'd2, 32'hF);
        @(negedge clk_50);
        force dut.count_q = 16'hFFFF;
        preset_ffff = 1'b1;
        @(negedge clk_50);
        release dut.count_q;
        preset_ffff = 1'b0;
        key_n = 4'h0;
        idle(14);
        rd(2'd3, v); check("wrap_count", v, 32'h1);
        rd(2'd2, v); check("wrap_edge", v, 32'hC);

        // Edge clear colliding with a new key-2 press
        @(negedge clk_50); key_n[2] = 1'b1;
        idle(14);
        wr(2'd1, 32'h4);
        check("setwin_irq_pre", {31'd0, irq}, 32'd1);
        @(negedge clk_50); key_n[2] = 1'b0;
        repeat (D + 1) @(posedge clk_50);
        @(negedge clk_50);
        avs_write = 1'b1; avs_address = 2'd2; avs_writedata = 32'h4;
        @(posedge clk_50);
        #1 check("setwin_irq", {31'd0, irq}, 32'd1);
        @(negedge clk_50);
        avs_write = 1'b0;
        rd(2'd2, v); check("setwin_edge", v, 32'hC);
        rd(2'd3, v); check("setwin_count", v, 32'h2);
        wr(2'd2, 32'h4);
        check("clear_irq_drop", {31'd0, irq}, 32'd0);
        rd(2'd2, v); check("clear_edge", v, 32'h8);

        // Reset mid-debounce with key 0 held
        @(negedge clk_50); key_n = 4'hF;
        idle(14);
        @(negedge clk_50); key_n = 4'hE;
        idle(2);
        rd(2'd3, v); check("pre_rst_count", v, 32'h2);
        @(negedge clk_50);
        global_reset_n = 1'b0;
        #1 check("rst_mid_readdata", avs_readdata, 32'h0);
        check("rst_mid_irq", {31'd0, irq}, 32'd0);
        @(negedge clk_50);
        global_reset_n = 1'b1; avs_read = 1'b1; avs_address = 2'd0;
        repeat (D + 2) @(posedge clk_50);
        #1 check("rel_data_before", avs_readdata, 32'h0);
        @(posedge clk_50);
        #1 check("rel_data_after", avs_readdata, 32'h1);
        @(negedge clk_50);
        avs_read = 1'b0;
        rd(2'd2, v); check("rel_edge", v, 32'h1);
        rd(2'd3, v); check("rel_count", v, 32'h1);
        rd(2'd1, v); check("rel_mask", v, 32'h0);

        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/key_input_pio.md
# key_input_pio

Debounced push-button input port for the hollywood_hash system: the input-side counterpart of the LED output PIO. Samples raw active-low board keys on `clk_50`, synchronises and debounces them, and presents the pressed state, latched press events, a press counter and an interrupt to the processor over an Avalon-MM slave.

## Interface
- `WIDTH`, default 4: number of keys, 1..16.
- `DEBOUNCE_CYCLES`, default 500000: stable-input cycles required before a key state change is accepted (10 ms at 50 MHz); minimum 2.

- `clk_50`  in  1  system clock; all logic is single-clock.
- `global_reset_n`  in  1  asynchronous active-low reset.
- `key_n`  in  WIDTH  raw keys, asynchronous to `clk_50`, 0 = pressed.
- `avs_address`  in  2  word address.
- `avs_read`  in  1  read strobe.
- `avs_write`  in  1  write strobe.
- `avs_writedata`  in  32  write data.
- `avs_readdata`  out  32  read data, registered.
- `irq`  out  1  level interrupt, active high.

## Operation
- Per key: 2-flop synchroniser on inverted `key_n` (`sync`, 1 = pressed), debounce counter, accepted `state`.
- Debounce: if `sync == state`, counter clears to 0. Otherwise, if counter `== DEBOUNCE_CYCLES-1`, `state <= sync` and counter clears; else counter increments. Any bounce back to `state` restarts the count.
- Press event: `state` bit goes 0->1. Releases generate no event.
- Register map (unused bits read 0):
  - 0 DATA (RO): `state[WIDTH-1:0]`. Writes ignored.
  - 1 MASK (RW): `mask[WIDTH-1:0]`, interrupt enable per key.
  - 2 EDGE (RW1C): `edge[WIDTH-1:0]`. Set on a press event. A write of 1 clears that bit. If a set and a clear hit the same bit in the same cycle, the set wins.
  - 3 COUNT (RO, write clears): `count[15:0]`.
    - Each cycle adds the popcount of that cycle's press events, modulo 2^16 (0xFFFF + 1 = 0x0000).
    - Any write to address 3 clears the count. That cycle's events are still added, so the result equals their popcount.
- `irq = |(edge & mask)`. This is combinational from registers only.
- Simultaneous read and write: the read returns the pre-write value.

## Timing
- Reset (asynchronous assert) clears all of the following:
  - `avs_readdata` = 0, `irq` = 0.
  - `state`, synchronisers, counters, `mask`, `edge`, `count` = 0.
- Reset release:
  - Keys held through reset are treated as new presses.
  - They are accepted after debounce and produce edge and count events.
- Reset asserted mid-debounce or mid-access: everything returns to its reset value immediately. No partial state survives.
- Key latency:
  - A `key_n` change registered at edge k appears on `sync` after edge k+1.
  - With no bounce, `state`, `edge` and `count` update at edge k+1+`DEBOUNCE_CYCLES`.
  - `irq` follows in the same cycle.
- Read latency is fixed at 1. `avs_readdata` is valid the cycle after `avs_read`. With no read, `avs_readdata` holds its last value. No waitrequest.
- Writes take effect at the edge where `avs_write` is sampled.
- Clearing `edge` deasserts `irq` in the next cycle, unless a new press on an enabled key lands in the same cycle.

## Test plan
Bench parameters: `WIDTH`=4, `DEBOUNCE_CYCLES`=8.

- Reset with keys idle (`key_n`=4'hF) -> all outputs 0; reads of addresses 0..3 return 0.
- Clean press on key 0, held 20 cycles:
  - DATA=0x1 exactly 9 cycles after `key_n[0]` falls.
  - EDGE=0x1, COUNT=1.
  - `irq` stays 0 while MASK=0; it rises after writing MASK=0x1.
- Bounce key 1 low for 5 cycles, high for 2, then low steady:
  - No DATA change during the bounce.
  - DATA[1]=1 only 8 cycles after the final transition is synchronised.
  - COUNT increments by exactly 1.
- Keys 2 and 3 pressed in the same cycle, with COUNT at 0xFFFF beforehand -> COUNT=0x0001 (wrap plus popcount 2), EDGE=0xC.
- Write EDGE=0x4 in the same cycle a new key-2 press event occurs -> EDGE[2] stays 1 (set wins) and `irq` stays high with MASK=0x4. A later write of 0x4 with no event clears EDGE[2], and `irq` drops the next cycle.
- Press key 0, then assert `global_reset_n` low mid-debounce for 1 cycle with key still held:
  - All registers return to 0.
  - After release, DATA[0]=1, EDGE=0x1 and COUNT=1 appear `DEBOUNCE_CYCLES`+2 cycles later.
